// File: rtl/renode_apb3_requester.sv
// renode_apb3_requester: APB3 requester (manager). It accepts single-beat commands on a
// valid/ready command port and runs each one as an APB3 SETUP/ACCESS transfer. Read data and
// error status are returned on a valid/ready response port. Only one transfer is outstanding.
//
// Optional feature: define APB3_REQ_TIMEOUT_EN to abort an ACCESS phase once pready has stayed
// low for TimeoutCycles cycles. Without it, ACCESS waits for pready for as long as it takes.
//
// Ports:
//   pclk_i, preset_i         clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_rdata_o, rsp_error_o, rsp_timeout_o
//   paddr_o, pselx_o, penable_o, pwrite_o, pwdata_o        APB3 requester outputs
//   pready_i, prdata_i, pslverr_i                          APB3 completer inputs
module renode_apb3_requester #(
  parameter int unsigned AddressWidth  = 20,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [AddressWidth-1:0] cmd_addr_i,
  input  logic [DataWidth-1:0]    cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DataWidth-1:0]    rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic                    rsp_timeout_o,
  output logic [AddressWidth-1:0] paddr_o,
  output logic                    pselx_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DataWidth-1:0]    pwdata_o,
  input  logic                    pready_i,
  input  logic [DataWidth-1:0]    prdata_i,
  input  logic                    pslverr_i
);

  if (!(DataWidth inside {8, 16, 24, 32})) begin : g_bad_data_width
    $error("renode_apb3_requester: DataWidth must be 8, 16, 24 or 32");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("renode_apb3_requester: TimeoutCycles must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DataWidth-1:0]    pwdata_q, pwdata_d;
  logic [DataWidth-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;

`ifdef APB3_REQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  // Count value seen in the last pready-low ACCESS cycle before the abort.
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB3_REQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
`ifdef APB3_REQ_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StAccess;
      end
      StAccess: begin
        // pready wins over an expiring timeout in the same cycle.
        if (pready_i) begin
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          rsp_error_d = pslverr_i;
`ifdef APB3_REQ_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = StResp;
`ifdef APB3_REQ_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef APB3_REQ_TIMEOUT_EN
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  // cmd_ready is also masked by reset so every output reads 0 while reset is held.
  assign cmd_ready_o = (state_q == StIdle) && !preset_i;
  assign pselx_o     = (state_q == StSetup) || (state_q == StAccess);
  assign penable_o   = (state_q == StAccess);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_renode_apb3_requester.sv
// Self-checking bench for renode_apb3_requester: directed scenarios plus randomized transfers,
// each checked against a transaction-level model of the expected APB phases and response.
module tb_renode_apb3_requester;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
`ifdef APB3_REQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          pclk, preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pselx, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  renode_apb3_requester #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) u_dut (
    .pclk_i       (pclk),
    .preset_i     (preset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pselx_o      (pselx),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pready_i     (pready),
    .prdata_i     (prdata),
    .pslverr_i    (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One complete transfer. wait_n = ACCESS cycles with pready low before pready rises,
  // rsp_delay = RESP cycles with rsp_ready low, pend = offer a stray command meanwhile.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int wait_n, input bit slverr,
                         input int rsp_delay, input bit pend);
    logic [DW-1:0] exp_pwdata, exp_rdata;
    bit            exp_err, exp_to, fin;
    int            i;
    exp_pwdata = wr ? wdata : '0;
    exp_rdata  = '0;
    exp_err    = 1'b0;
    exp_to     = 1'b0;
    check_eq("idle_cmd_ready", cmd_ready, 1);
    check_eq("idle_pselx", pselx, 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    // SETUP: scramble the command port, which must now be ignored.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    rsp_ready = 1'($urandom_range(0, 1));
    check_eq("setup_pselx", pselx, 1);
    check_eq("setup_penable", penable, 0);
    check_eq("setup_paddr", paddr, addr);
    check_eq("setup_pwrite", pwrite, wr);
    check_eq("setup_pwdata", pwdata, exp_pwdata);
    check_eq("setup_cmd_ready", cmd_ready, 0);
    check_eq("setup_rsp_valid", rsp_valid, 0);
    tick();
    i   = 0;
    fin = 1'b0;
    while (!fin) begin
      check_eq("access_pselx", pselx, 1);
      check_eq("access_penable", penable, 1);
      check_eq("access_paddr", paddr, addr);
      check_eq("access_pwrite", pwrite, wr);
      check_eq("access_pwdata", pwdata, exp_pwdata);
      check_eq("access_rsp_valid", rsp_valid, 0);
      pready    = (i >= wait_n);
      pslverr   = pready ? slverr : 1'($urandom_range(0, 1));
      prdata    = pready ? rdata : $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      if (pready) begin
        exp_err   = slverr;
        exp_rdata = (wr || slverr) ? '0 : rdata;
        fin       = 1'b1;
      end else if (TimeoutEn && (i + 1 == TO)) begin
        exp_err = 1'b1;
        exp_to  = 1'b1;
        fin     = 1'b1;
      end else begin
        i++;
        if (i > 200) begin
          check_eq("access_bound", 64'(i), 64'(wait_n));
          fin = 1'b1;
        end
      end
    end
    pready  = 1'b0;
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    for (int d = 0; d <= rsp_delay; d++) begin
      check_eq("resp_valid", rsp_valid, 1);
      check_eq("resp_pselx", pselx, 0);
      check_eq("resp_penable", penable, 0);
      check_eq("resp_rdata", rsp_rdata, exp_rdata);
      check_eq("resp_error", rsp_error, exp_err);
      check_eq("resp_timeout", rsp_timeout, exp_to);
      check_eq("resp_cmd_ready", cmd_ready, 0);
      rsp_ready = (d == rsp_delay);
      cmd_valid = pend;
      tick();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_cmd_ready", cmd_ready, 1);
    check_eq("post_pselx", pselx, 0);
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    #12;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_pselx", pselx, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_pwdata", pwdata, 0);
    check_eq("rst_rsp_fields", {rsp_rdata, rsp_error, rsp_timeout}, 0);
    @(posedge pclk);
    #1 preset = 1'b0;
    tick();

    // Zero-wait write, waited read, read error, stalled response with a pending command.
    do_xfer(1'b1, 20'h00010, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 1'b0);
    do_xfer(1'b0, 20'h00ABC, 32'h0, 32'h12345678, 3, 1'b0, 0, 1'b0);
    do_xfer(1'b0, 20'h00ABD, 32'h0, 32'hCAFEF00D, 1, 1'b1, 0, 1'b0);
    do_xfer(1'b1, 20'h00123, 32'h0BADCAFE, 32'h0, 0, 1'b0, 5, 1'b1);
    do_xfer(1'b0, 20'hFFFFF, 32'h0, 32'hFFFFFFFF, 0, 1'b0, 0, 1'b0);

    // Reset mid-ACCESS: strobes drop at once and no response appears.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 20'h55555;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("pre_rst_penable", penable, 1);
    #2 preset = 1'b1;
    #1;
    check_eq("arst_pselx", pselx, 0);
    check_eq("arst_penable", penable, 0);
    check_eq("arst_rsp_valid", rsp_valid, 0);
    @(posedge pclk);
    #1 preset = 1'b0;
    pready = 1'b1;
    tick();
    tick();
    pready = 1'b0;
    check_eq("after_rst_rsp_valid", rsp_valid, 0);
    check_eq("after_rst_pselx", pselx, 0);
    check_eq("after_rst_paddr", paddr, 0);
    do_xfer(1'b1, 20'h00200, 32'h5A5A5A5A, 32'h0, 2, 1'b0, 1, 1'b0);

    if (TimeoutEn) begin
      // Stuck pready aborts; pready on the last allowed cycle completes normally.
      do_xfer(1'b0, 20'h00300, 32'h0, 32'h11111111, 1000, 1'b0, 0, 1'b0);
      do_xfer(1'b0, 20'h00304, 32'h0, 32'h22222222, TO - 1, 1'b0, 0, 1'b0);
      do_xfer(1'b1, 20'h00308, 32'h33333333, 32'h0, TO, 1'b0, 0, 1'b0);
    end

    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
